// File: rtl/spireg_pkg.sv
// Shared definitions for the SPI register-access master: command op codes,
// FSM state encoding and the command-byte builder.
package spireg_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_RSVD  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_FAST  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_WAITWR = 3'd3,
        ST_GAP    = 3'd4
    } spireg_state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op_i, input logic [5:0] addr6);
        return {op_i, addr6};
    endfunction

endpackage

// File: rtl/spireg_sclkgen.sv
// SPI mode-0 clock generator: sclk low/high phases of CLK_DIV clk cycles each,
// with strobes one cycle ahead of each sclk edge and a mid-low mosi strobe.
module spireg_sclkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall,
    output logic mid
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MID_I = (CLK_DIV / 2 < 1) ? 1 : CLK_DIV / 2;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] MIDC = CW'(MID_I - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_wrap;

    assign w_wrap = en && (r_cnt == LAST);
    assign rise   = w_wrap && !r_sclk;
    assign fall   = w_wrap && r_sclk;
    // mosi is registered on this strobe, so it lands MID_I cycles after the fall
    assign mid    = en && !r_sclk && (r_cnt == MIDC);
    assign sclk   = r_sclk;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spireg_master.sv
// SPI register-access master: command byte {op, addr}, then len+1 REG_W words
// sent byte 0 first, MSB first within each byte, with a status byte returned.
module spireg_master
    import spireg_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int REG_W   = 16,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [REG_W-1:0]  wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [REG_W-1:0]  rd_data,
    output logic              rd_vld,
    output logic [7:0]        status,
    output logic              status_vld,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              nss
);

    localparam int BW = $clog2(REG_W) + 1;
    localparam int IW = $clog2(REG_W);
    localparam int TW = 16;

    spireg_state_t    r_state;
    logic [1:0]       r_op;
    logic [7:0]       r_len;
    logic [REG_W-1:0] r_tx;
    logic [REG_W-1:0] r_rx;
    logic [BW-1:0]    r_bit;
    logic [8:0]       r_wcnt;
    logic [TW-1:0]    r_tcnt;
    logic             r_cmd;
    logic             r_busy;
    logic             r_done;
    logic             r_nss;
    logic             r_mosi;
    logic             r_rd_vld;
    logic             r_status_vld;
    logic [REG_W-1:0] r_rd_data;
    logic [7:0]       r_status;
    logic             r_miso_s1;
    logic             r_miso_s2;

    logic             w_rise;
    logic             w_fall;
    logic             w_mid;
    logic [IW-1:0]    w_idx;
    logic             w_last;
    logic             w_more;
    logic [REG_W-1:0] w_rx_nxt;
    logic [7:0]       w_cmd;

    spireg_sclkgen #(.CLK_DIV(CLK_DIV)) u_sclkgen (
        .clk  (clk),
        .nrst (nrst),
        .en   (r_state == ST_SHIFT),
        .sclk (sclk),
        .rise (w_rise),
        .fall (w_fall),
        .mid  (w_mid)
    );

    // Wire order is byte 0 first, MSB first: flip the low three index bits.
    assign w_idx    = r_bit[IW-1:0] ^ IW'(7);
    assign w_last   = (r_bit == (r_cmd ? BW'(7) : BW'(REG_W - 1)));
    assign w_more   = r_cmd || (r_wcnt != {1'b0, r_len});
    assign w_cmd    = cmd_byte(op, 6'(addr));

    always_comb begin
        w_rx_nxt        = r_rx;
        w_rx_nxt[w_idx] = r_miso_s2;
    end

    // Write handshake: a word moves when wr_valid && wr_ready at a clk edge;
    // ready is offered only at a word boundary or while stalled in WAITWR.
    assign wr_ready = wr_valid && ((r_state == ST_WAITWR) ||
                      ((r_state == ST_SHIFT) && w_fall && w_last && w_more && (r_op == OP_WRITE)));

    assign rd_data    = r_rd_data;
    assign rd_vld     = r_rd_vld;
    assign status     = r_status;
    assign status_vld = r_status_vld;
    assign busy       = r_busy;
    assign done       = r_done;
    assign mosi       = r_mosi;
    assign nss        = r_nss;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_READ;
            r_len        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_bit        <= '0;
            r_wcnt       <= '0;
            r_tcnt       <= '0;
            r_cmd        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_nss        <= 1'b1;
            r_mosi       <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_status_vld <= 1'b0;
            r_rd_data    <= '0;
            r_status     <= '0;
        end else begin
            r_rd_vld     <= 1'b0;
            r_status_vld <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (op != OP_RSVD)) begin
                        r_op    <= op;
                        r_len   <= len;
                        r_tx    <= REG_W'(w_cmd);
                        r_cmd   <= 1'b1;
                        r_bit   <= '0;
                        r_wcnt  <= '0;
                        r_tcnt  <= TW'(CLK_DIV - 1);
                        r_busy  <= 1'b1;
                        r_nss   <= 1'b0;
                        r_mosi  <= w_cmd[7];
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_tcnt == '0) r_state <= ST_SHIFT;
                    else r_tcnt <= r_tcnt - 1'b1;
                end
                ST_SHIFT: begin
                    if (w_mid) r_mosi <= r_tx[w_idx];
                    if (w_rise) begin
                        r_rx <= w_rx_nxt;
                        if (r_cmd && w_last) begin
                            r_status     <= w_rx_nxt[7:0];
                            r_status_vld <= 1'b1;
                        end
                        if (!r_cmd && w_last && (r_op == OP_READ)) begin
                            r_rd_data <= w_rx_nxt;
                            r_rd_vld  <= 1'b1;
                        end
                    end
                    if (w_fall) begin
                        if (!w_last) begin
                            r_bit <= r_bit + 1'b1;
                        end else begin
                            r_bit <= '0;
                            if ((r_cmd && (r_op == OP_FAST)) || !w_more) begin
                                r_nss   <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_tcnt  <= TW'(GAP - 1);
                                r_done  <= (GAP == 1);
                                r_state <= ST_GAP;
                            end else begin
                                r_cmd <= 1'b0;
                                if (!r_cmd) r_wcnt <= r_wcnt + 1'b1;
                                if (r_op == OP_WRITE) begin
                                    if (wr_valid) r_tx <= wr_data;
                                    else r_state <= ST_WAITWR;
                                end else begin
                                    r_tx <= '0;
                                end
                            end
                        end
                    end
                end
                ST_WAITWR: begin
                    if (wr_valid) begin
                        r_tx    <= wr_data;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    if (r_tcnt == TW'(1)) r_done <= 1'b1;
                    if (r_tcnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
